decode_issue_ctrl: RTL and testbench

//  Sequences instruction words from a fetch source into the decode unit under formal/sim check.
//  - Buffers incoming words in a 2-entry FIFO.
//  - Issues them in order, tagging each with PC and a monotonic RVFI order number.
//  - Bounds outstanding decodes and tracks retires.
//  - On a trapping retire: stops issue, flushes, drains, then waits for a PC redirect.

---
 rtl/decode_issue_pkg.sv | 21 ++
 rtl/decode_issue_ctrl_if.sv | 37 +++
 rtl/decode_issue_ctrl_issue_fifo2.sv | 44 ++++
 rtl/decode_issue_ctrl.sv | 102 ++++++++++
 tb/tb_decode_issue_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_issue_pkg.sv
// Shared types and constants for the decode issue controller slice.
package decode_issue_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALT   = 2'd2,
    SERIAL = 2'd3
  } issue_state_e;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] insn;
  } issue_entry_t;

  function automatic logic is_system(input issue_entry_t e);
    return e.insn[6:0] == OPC_SYSTEM;
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Fetch, decode-issue, retire and redirect signals of decode_issue_ctrl.
interface decode_issue_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int ORDER_W = 64,
  parameter int MAX_OUT = 4
);
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_insn;
  logic               dec_valid;
  logic               dec_ready;
  logic [31:0]        dec_insn;
  logic [XLEN-1:0]    dec_pc;
  logic [ORDER_W-1:0] dec_order;
  logic               ret_valid;
  logic               ret_trap;
  logic               redir_valid;
  logic               redir_ready;
  logic [XLEN-1:0]    redir_pc;
  logic               halted;
  logic [OUT_W-1:0]   outstanding;
  logic               proto_err;

  modport master (
    output in_valid, in_insn, dec_ready, ret_valid, ret_trap, redir_valid, redir_pc,
    input  in_ready, dec_valid, dec_insn, dec_pc, dec_order, redir_ready, halted,
           outstanding, proto_err
  );

  modport slave (
    input  in_valid, in_insn, dec_ready, ret_valid, ret_trap, redir_valid, redir_pc,
    output in_ready, dec_valid, dec_insn, dec_pc, dec_order, redir_ready, halted,
           outstanding, proto_err
  );
endinterface

// File: rtl/decode_issue_ctrl_issue_fifo2.sv
// Two-entry valid/ready FIFO with synchronous flush (flush beats push/pop).
module issue_fifo2
  import decode_issue_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_flush,
  input  logic         i_push,
  input  issue_entry_t i_data,
  input  logic         i_pop,
  output issue_entry_t o_data,
  output logic         o_full,
  output logic         o_empty
);
  issue_entry_t r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign w_pop   = i_pop && !o_empty;
  // A push into a full FIFO is accepted when the head leaves on the same edge.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (!reset || i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end
endmodule

// File: rtl/decode_issue_ctrl.sv
// In-order issue sequencer feeding the decoder; trap -> drain -> halt -> redirect.
// Optional DECODE_ISSUE_SERIAL_SYSTEM_EN serialises SYSTEM-opcode words.
module decode_issue_ctrl
  import decode_issue_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h0,
  parameter int              MAX_OUT  = 4,
  parameter int              ORDER_W  = 64
) (
  input logic              clk,
  input logic              reset,
  decode_issue_ctrl_if.slave bus
);
  localparam int               OUT_W     = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

  issue_state_e       r_state, w_state_next;
  logic [XLEN-1:0]    r_pc;
  logic [ORDER_W-1:0] r_order;
  logic [OUT_W-1:0]   r_out, w_out_next;
  logic               r_perr;

  issue_entry_t w_head, w_in_entry;
  logic w_full, w_empty, w_accept_state, w_head_ok;
  logic w_in_ready, w_dec_valid, w_trap, w_issue, w_push, w_ret_ok;

`ifdef DECODE_ISSUE_SERIAL_SYSTEM_EN
  assign w_accept_state = (r_state == RUN) || (r_state == SERIAL);
  assign w_head_ok      = !is_system(w_head) || (r_out == '0);
`else
  assign w_accept_state = (r_state == RUN);
  assign w_head_ok      = 1'b1;
`endif

  assign w_in_entry  = '{insn: bus.in_insn};
  assign w_in_ready  = reset && !w_full && w_accept_state;
  assign w_dec_valid = reset && (r_state == RUN) && !w_empty && (r_out < MAX_OUT_C) && w_head_ok;
  // A trapping retire wins over an issue handshake presented on the same edge.
  assign w_trap      = bus.ret_valid && bus.ret_trap && w_accept_state;
  assign w_issue     = w_dec_valid && bus.dec_ready && !w_trap;
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_ret_ok    = bus.ret_valid && (r_out != '0);
  assign w_out_next  = r_out + OUT_W'(w_issue) - OUT_W'(w_ret_ok);

  issue_fifo2 u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_trap),
    .i_push  (w_push),
    .i_data  (w_in_entry),
    .i_pop   (w_issue),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (w_trap) w_state_next = DRAIN;
`ifdef DECODE_ISSUE_SERIAL_SYSTEM_EN
        else if (w_issue && is_system(w_head)) w_state_next = SERIAL;
`endif
      end
      DRAIN:  if (w_out_next == '0) w_state_next = HALT;
      HALT:   if (bus.redir_valid) w_state_next = RUN;
`ifdef DECODE_ISSUE_SERIAL_SYSTEM_EN
      SERIAL: if (bus.ret_valid) w_state_next = bus.ret_trap ? DRAIN : RUN;
`endif
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_order <= '0;
      r_out   <= '0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_out   <= w_out_next;
      if (bus.ret_valid && (r_out == '0)) r_perr <= 1'b1;
      if ((r_state == HALT) && bus.redir_valid) r_pc <= bus.redir_pc;
      else if (w_issue) r_pc <= r_pc + XLEN'(4);
      if (w_issue) r_order <= r_order + ORDER_W'(1);
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.dec_valid   = w_dec_valid;
  assign bus.dec_insn    = w_head.insn;
  assign bus.dec_pc      = r_pc;
  assign bus.dec_order   = r_order;
  assign bus.redir_ready = reset && (r_state == HALT);
  assign bus.halted      = (r_state == HALT);
  assign bus.outstanding = r_out;
  assign bus.proto_err   = r_perr;
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl against a queue-based behavioural model.
module tb_decode_issue_ctrl;
  import decode_issue_pkg::*;

  localparam int          XLEN     = 32;
  localparam int          MAX_OUT  = 4;
  localparam int          ORDER_W  = 64;
  localparam int          OUT_W    = $clog2(MAX_OUT + 1);
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] ADD_A    = 32'h00B50533;
  localparam logic [31:0] ADD_B    = 32'h00C58633;
  localparam logic [31:0] ECALL_W  = 32'h00000073;
`ifdef DECODE_ISSUE_SERIAL_SYSTEM_EN
  localparam bit SER = 1'b1;
`else
  localparam bit SER = 1'b0;
`endif
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2, M_SERIAL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_issue_ctrl_if #(.XLEN(XLEN), .ORDER_W(ORDER_W), .MAX_OUT(MAX_OUT)) bus ();

  decode_issue_ctrl #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .MAX_OUT(MAX_OUT), .ORDER_W(ORDER_W)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: FIFO as a queue, counters as plain integers.
  logic [31:0] fq[$];
  logic [31:0] m_pc = RESET_PC;
  logic [63:0] m_order = '0;
  int          m_out = 0;
  int          m_mode = M_RUN;
  bit          m_perr = 1'b0;

  function automatic bit m_head_sys();
    logic [31:0] h;
    if (fq.size() == 0) return 1'b0;
    h = fq[0];
    return h[6:0] == 7'b1110011;
  endfunction

  function automatic bit m_in_ready();
    return rst_n && (fq.size() < 2) && (m_mode == M_RUN || m_mode == M_SERIAL);
  endfunction

  function automatic bit m_dec_valid();
    return rst_n && (m_mode == M_RUN) && (fq.size() > 0) && (m_out < MAX_OUT)
           && !(SER && m_head_sys() && m_out != 0);
  endfunction

  task automatic model_edge();
    bit rdy, dv, trap, iss, hsys;
    int old_mode;
    if (!rst_n) begin
      fq.delete(); m_pc = RESET_PC; m_order = '0; m_out = 0; m_mode = M_RUN; m_perr = 1'b0;
      return;
    end
    rdy = m_in_ready(); dv = m_dec_valid(); hsys = m_head_sys(); old_mode = m_mode;
    trap = bus.ret_valid && bus.ret_trap && (m_mode == M_RUN || m_mode == M_SERIAL);
    iss  = dv && bus.dec_ready && !trap;
    if (bus.ret_valid) begin
      if (m_out == 0) m_perr = 1'b1;
      else m_out--;
    end
    if (iss) begin
      void'(fq.pop_front()); m_pc += 32'd4; m_order++; m_out++;
    end
    if (rdy && bus.in_valid) fq.push_back(bus.in_insn);
    case (old_mode)
      M_RUN: begin
        if (trap) begin m_mode = M_DRAIN; fq.delete(); end
        else if (SER && iss && hsys) m_mode = M_SERIAL;
      end
      M_DRAIN: if (m_out == 0) m_mode = M_HALT;
      M_HALT: if (bus.redir_valid) begin m_pc = bus.redir_pc; m_mode = M_RUN; end
      default: if (bus.ret_valid) begin
        if (bus.ret_trap) begin m_mode = M_DRAIN; fq.delete(); end
        else m_mode = M_RUN;
      end
    endcase
  endtask

  function automatic logic [135:0] exp_vec();
    logic [127:0] pay;
    logic dv;
    pay = '0;
    dv = m_dec_valid();
    if (dv) pay = {fq[0], m_pc, m_order};
    return {dv, m_in_ready(), rst_n && (m_mode == M_HALT), m_mode == M_HALT,
            OUT_W'(m_out), m_perr, pay};
  endfunction

  function automatic logic [135:0] obs_vec();
    logic [127:0] pay;
    pay = '0;
    if (bus.dec_valid === 1'b1) pay = {bus.dec_insn, bus.dec_pc, bus.dec_order};
    return {bus.dec_valid, bus.in_ready, bus.redir_ready, bus.halted,
            bus.outstanding, bus.proto_err, pay};
  endfunction

  task automatic drive(input bit iv, input logic [31:0] insn, input bit dr, input bit rv,
                       input bit rt, input bit rdv, input logic [31:0] rpc);
    bus.in_valid = iv; bus.in_insn = insn; bus.dec_ready = dr; bus.ret_valid = rv;
    bus.ret_trap = rt; bus.redir_valid = rdv; bus.redir_pc = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, '0, 0, 0, 0, 0, '0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  function automatic logic [31:0] rand_alu();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = 7'b0110011;
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, 1, 1, 1, 1, $urandom);
      tick();
      n_checks++;
      if ({bus.dec_valid, bus.in_ready, bus.redir_ready, bus.outstanding, bus.proto_err}
          !== {3'b000, 3'd0, 1'b0}) begin
        n_errors++;
        $display("FAIL reset_hold: got %b%b%b out=%0d perr=%b want 000 out=0 perr=0",
                 bus.dec_valid, bus.in_ready, bus.redir_ready, bus.outstanding, bus.proto_err);
      end
    end
    drive(0, '0, 0, 0, 0, 0, '0);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.dec_valid, bus.halted} !== 3'b100) begin
      n_errors++;
      $display("FAIL reset_release: got in_ready=%b dec_valid=%b halted=%b want 1 0 0",
               bus.in_ready, bus.dec_valid, bus.halted);
    end
  endtask

  task automatic test_basic();
    logic [31:0] pcs[$];
    logic [63:0] ords[$];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(i < 3, rand_alu(), 1, 0, 0, 0, '0);
      if (i == 0) begin
        n_checks++;
        if (bus.dec_valid !== 1'b0) begin
          n_errors++; $display("FAIL basic_early_issue: got dec_valid=%b want 0", bus.dec_valid);
        end
      end
      if (bus.dec_valid === 1'b1) begin pcs.push_back(bus.dec_pc); ords.push_back(bus.dec_order); end
      tick();
      if (i == 0) begin
        n_checks++;
        if (bus.dec_valid !== 1'b1) begin
          n_errors++; $display("FAIL basic_next_edge: got dec_valid=%b want 1", bus.dec_valid);
        end
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL basic_model: got %h want %h", obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (pcs.size() != 3 || pcs[0] !== 32'd0 || pcs[1] !== 32'd4 || pcs[2] !== 32'd8 ||
        ords[0] !== 64'd0 || ords[1] !== 64'd1 || ords[2] !== 64'd2 || bus.outstanding !== 3'd3) begin
      n_errors++;
      $display("FAIL basic_seq: got n=%0d out=%0d want pc 0,4,8 order 0,1,2 out=3",
               pcs.size(), bus.outstanding);
    end
  endtask

  task automatic test_max_out();
    int pushed = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(pushed < 6, rand_alu(), 1, 0, 0, 0, '0);
      if (bus.in_valid && bus.in_ready === 1'b1) pushed++;
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL maxout_model: got %h want %h", obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({bus.outstanding, bus.dec_valid, bus.in_ready} !== {3'd4, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL maxout_cap: got out=%0d dv=%b ir=%b want out=4 dv=0 ir=0",
               bus.outstanding, bus.dec_valid, bus.in_ready);
    end
    drive(0, '0, 1, 1, 0, 0, '0);
    tick();
    n_checks++;
    if ({bus.outstanding, bus.dec_valid, bus.dec_pc, bus.dec_order} !== {3'd3, 1'b1, 32'd16, 64'd4}) begin
      n_errors++;
      $display("FAIL maxout_fifth: got out=%0d dv=%b pc=%h ord=%0d want 3 1 10 4",
               bus.outstanding, bus.dec_valid, bus.dec_pc, bus.dec_order);
    end
    drive(0, '0, 1, 0, 0, 0, '0);
    tick();
    n_checks++;
    if ({bus.outstanding, bus.dec_valid, bus.in_ready} !== {3'd4, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL maxout_after: got out=%0d dv=%b ir=%b want 4 0 1",
               bus.outstanding, bus.dec_valid, bus.in_ready);
    end
  endtask

  task automatic test_trap_drain();
    logic [31:0] w4;
    w4 = rand_alu();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(i != 2, rand_alu(), i < 3, 0, 0, 0, '0);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL trap_fill_model: got %h want %h", obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({bus.outstanding, bus.in_ready, bus.dec_valid} !== {3'd2, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL trap_setup: got out=%0d ir=%b dv=%b want 2 0 1",
               bus.outstanding, bus.in_ready, bus.dec_valid);
    end
    drive(1, rand_alu(), 1, 1, 1, 0, '0);
    tick();
    n_checks++;
    if ({bus.outstanding, bus.dec_valid, bus.in_ready, bus.halted} !== {3'd1, 3'b000}) begin
      n_errors++;
      $display("FAIL trap_drain: got out=%0d dv=%b ir=%b halted=%b want 1 0 0 0",
               bus.outstanding, bus.dec_valid, bus.in_ready, bus.halted);
    end
    drive(0, '0, 1, 1, 1, 0, '0);
    tick();
    n_checks++;
    if ({bus.halted, bus.redir_ready, bus.outstanding, bus.proto_err} !== {2'b11, 3'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL trap_halt: got h=%b rr=%b out=%0d perr=%b want 1 1 0 0",
               bus.halted, bus.redir_ready, bus.outstanding, bus.proto_err);
    end
    drive(0, '0, 1, 0, 0, 1, 32'h100);
    tick();
    n_checks++;
    if ({bus.halted, bus.in_ready, bus.dec_valid} !== 3'b010) begin
      n_errors++;
      $display("FAIL trap_redirect: got h=%b ir=%b dv=%b want 0 1 0",
               bus.halted, bus.in_ready, bus.dec_valid);
    end
    drive(1, w4, 0, 0, 0, 0, '0);
    tick();
    n_checks++;
    if ({bus.dec_valid, bus.dec_insn, bus.dec_pc, bus.dec_order} !== {1'b1, w4, 32'h100, 64'd2}) begin
      n_errors++;
      $display("FAIL trap_resume: got dv=%b insn=%h pc=%h ord=%0d want 1 %h 100 2",
               bus.dec_valid, bus.dec_insn, bus.dec_pc, bus.dec_order, w4);
    end
  endtask

  task automatic test_concurrent();
    bit found = 1'b0;
    do_reset();
    for (int i = 0; i < 10 && !found; i++) begin
      drive(i < 3, rand_alu(), 1, 0, 0, 0, '0);
      if (bus.outstanding === 3'd2 && bus.dec_valid === 1'b1) begin
        bus.ret_valid = 1'b1; found = 1'b1;
      end
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL conc_model: got %h want %h", obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (!found || bus.outstanding !== 3'd2) begin
      n_errors++;
      $display("FAIL conc_issue_retire: got found=%b out=%0d want found=1 out=2", found, bus.outstanding);
    end
    drive(0, '0, 0, 1, 0, 0, '0);
    tick(); tick();
    n_checks++;
    if ({bus.outstanding, bus.proto_err} !== {3'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL conc_drain_to_zero: got out=%0d perr=%b want 0 0", bus.outstanding, bus.proto_err);
    end
    tick();
    drive(0, '0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({bus.outstanding, bus.proto_err} !== {3'd0, 1'b1}) begin
        n_errors++;
        $display("FAIL conc_proto_err: got out=%0d perr=%b want 0 1", bus.outstanding, bus.proto_err);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] w0, w1;
    w0 = rand_alu(); w1 = rand_alu();
    do_reset();
    drive(1, w0, 0, 0, 0, 0, '0); tick();
    drive(1, w1, 0, 0, 0, 0, '0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, rand_alu(), 0, 0, 0, 0, '0);
      tick();
      n_checks++;
      if ({bus.dec_valid, bus.in_ready, bus.dec_insn, bus.dec_pc, bus.dec_order}
          !== {1'b1, 1'b0, w0, 32'd0, 64'd0}) begin
        n_errors++;
        $display("FAIL stall_hold: got dv=%b ir=%b insn=%h pc=%h ord=%0d want 1 0 %h 0 0",
                 bus.dec_valid, bus.in_ready, bus.dec_insn, bus.dec_pc, bus.dec_order, w0);
      end
    end
    drive(0, '0, 1, 0, 0, 0, '0);
    tick();
    n_checks++;
    if ({bus.dec_insn, bus.dec_pc, bus.dec_order, bus.outstanding} !== {w1, 32'd4, 64'd1, 3'd1}) begin
      n_errors++;
      $display("FAIL stall_release: got insn=%h pc=%h ord=%0d out=%0d want %h 4 1 1",
               bus.dec_insn, bus.dec_pc, bus.dec_order, bus.outstanding, w1);
    end
  endtask

  task automatic test_system();
    logic [31:0] seq [3];
    seq[0] = ADD_A; seq[1] = ECALL_W; seq[2] = ADD_B;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, seq[i % 3], 1, 0, 0, 0, '0);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL sys_model: got %h want %h", obs_vec(), exp_vec());
      end
    end
`ifdef DECODE_ISSUE_SERIAL_SYSTEM_EN
    n_checks++;
    if ({bus.outstanding, bus.dec_valid} !== {3'd1, 1'b0}) begin
      n_errors++;
      $display("FAIL sys_wait: got out=%0d dv=%b want 1 0", bus.outstanding, bus.dec_valid);
    end
    drive(0, '0, 1, 1, 0, 0, '0); tick();
    n_checks++;
    if ({bus.dec_valid, bus.dec_insn, bus.dec_pc} !== {1'b1, ECALL_W, 32'd4}) begin
      n_errors++;
      $display("FAIL sys_ecall_ready: got dv=%b insn=%h pc=%h want 1 %h 4",
               bus.dec_valid, bus.dec_insn, bus.dec_pc, ECALL_W);
    end
    drive(0, '0, 1, 0, 0, 0, '0); tick(); tick();
    n_checks++;
    if ({bus.outstanding, bus.dec_valid, bus.in_ready} !== {3'd1, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL sys_serial: got out=%0d dv=%b ir=%b want 1 0 1",
               bus.outstanding, bus.dec_valid, bus.in_ready);
    end
    drive(0, '0, 0, 1, 0, 0, '0); tick();
    n_checks++;
    if ({bus.dec_valid, bus.dec_insn, bus.dec_pc, bus.dec_order} !== {1'b1, ADD_B, 32'd8, 64'd2}) begin
      n_errors++;
      $display("FAIL sys_after: got dv=%b insn=%h pc=%h ord=%0d want 1 %h 8 2",
               bus.dec_valid, bus.dec_insn, bus.dec_pc, bus.dec_order, ADD_B);
    end
`else
    n_checks++;
    if ({bus.outstanding, bus.dec_valid, bus.dec_pc, bus.dec_order} !== {3'd3, 1'b0, 32'd12, 64'd3}) begin
      n_errors++;
      $display("FAIL sys_plain: got out=%0d dv=%b pc=%h ord=%0d want 3 0 c 3",
               bus.outstanding, bus.dec_valid, bus.dec_pc, bus.dec_order);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] w, rpc;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      if ($urandom % 4 == 0) w[6:0] = 7'b1110011;
      rpc = ($urandom % 4 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      drive($urandom % 4 != 0, w, $urandom % 3 != 0,
            (bus.outstanding !== 3'd0) ? ($urandom % 3 == 0) : ($urandom % 50 == 0),
            $urandom % 8 == 0, $urandom % 3 == 0, rpc);
      rst_n = ($urandom % 300 != 0);
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL random_model: cyc=%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    drive(0, '0, 0, 0, 0, 0, '0);
    test_reset();
    test_basic();
    test_max_out();
    test_trap_drain();
    test_concurrent();
    test_stall();
    test_system();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
